// File: rtl/log_prod_accum.sv
// log_prod_accum: streaming dot-product accumulator for the signed Mitchell
// log-multiplier. Sums VEC_LEN signed products per result and holds each result
// on a valid/ready output until it is taken.
// Optional build macro: LOG_ACC_SAT_EN selects saturating adds and a sticky
// overflow flag. Without it the sum wraps and o_ovf is tied low.
module log_prod_accum #(
    parameter int PROD_W  = 16,
    parameter int ACC_W   = 24,
    parameter int VEC_LEN = 16,
    parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [PROD_W-1:0] i_prod,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ACC_W-1:0]  o_sum,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_ovf
);

    // state | meaning
    // S_ACC | accepting product beats into acc
    // S_OUT | holding a finished result until the output handshake
    typedef enum logic {S_ACC, S_OUT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [CNT_W-1:0]  count_q, count_d;
    logic        [ACC_W-1:0]  sum_q, sum_d;

    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  add_res;
    logic                     accept;
    logic                     out_hs;

    assign prod_s   = i_prod;
    assign prod_ext = ACC_W'(prod_s);
    assign accept   = i_valid && (state_q == S_ACC) && !i_clear;
    assign out_hs   = i_ready && (state_q == S_OUT) && !i_clear;

`ifdef LOG_ACC_SAT_EN
    logic signed [ACC_W:0] add_wide;
    logic                  add_clamp;
    logic                  ovf_q, ovf_d;

    // Saturating add: one extra bit exposes overflow, then clamp to range.
    always_comb begin
        add_wide  = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
        add_clamp = (add_wide[ACC_W] != add_wide[ACC_W-1]);
        if (add_clamp) begin
            add_res = add_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            add_res = add_wide[ACC_W-1:0];
        end
    end

    // Sticky overflow: set on any clamp, cleared by handshake or clear.
    always_comb begin
        ovf_d = ovf_q;
        if (i_clear || out_hs) begin
            ovf_d = 1'b0;
        end else if (accept && add_clamp) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_ovf = ovf_q;
`else
    assign add_res = acc_q + prod_ext;
    assign o_ovf   = 1'b0;
`endif

    // Next-state, accumulator, counter and result capture; clear wins.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        sum_d   = sum_q;
        if (i_clear) begin
            state_d = S_ACC;
            acc_d   = '0;
            count_d = '0;
        end else if (accept) begin
            acc_d   = add_res;
            count_d = count_q + CNT_ONE;
            if (count_q == CNT_LAST) begin
                sum_d   = add_res;
                state_d = S_OUT;
            end
        end else if (out_hs) begin
            state_d = S_ACC;
            acc_d   = '0;
            count_d = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_ACC;
            acc_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            sum_q   <= sum_d;
        end
    end

    assign o_ready = (state_q == S_ACC);
    assign o_valid = (state_q == S_OUT);
    assign o_sum   = sum_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_log_prod_accum.sv
// Bench for log_prod_accum: a table of per-cycle vectors on a VEC_LEN=4 /
// ACC_W=24 instance, plus hand sequences for narrow-accumulator overflow and
// asynchronous reset.
module tb_log_prod_accum;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: ACC_W=24, VEC_LEN=4
    logic        va = 1'b0, clra = 1'b0, rdya = 1'b0;
    logic [15:0] proda = '0;
    logic        ordya, ovala, ovfa;
    logic [23:0] suma;
    logic [2:0]  cnta;

    // Instance B: ACC_W=16, VEC_LEN=2
    logic        vb = 1'b0, clrb = 1'b0, rdyb = 1'b0;
    logic [15:0] prodb = '0;
    logic        ordyb, ovalb, ovfb;
    logic [15:0] sumb;
    logic [1:0]  cntb;

    // Instance C: ACC_W=16, VEC_LEN=3
    logic        vc = 1'b0, clrc = 1'b0, rdyc = 1'b0;
    logic [15:0] prodc = '0;
    logic        ordyc, ovalc, ovfc;
    logic [15:0] sumc;
    logic [1:0]  cntc;

    log_prod_accum #(.PROD_W(16), .ACC_W(24), .VEC_LEN(4)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clra), .i_valid(va), .o_ready(ordya),
        .i_prod(proda), .o_valid(ovala), .i_ready(rdya), .o_sum(suma), .o_count(cnta),
        .o_ovf(ovfa));

    log_prod_accum #(.PROD_W(16), .ACC_W(16), .VEC_LEN(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clrb), .i_valid(vb), .o_ready(ordyb),
        .i_prod(prodb), .o_valid(ovalb), .i_ready(rdyb), .o_sum(sumb), .o_count(cntb),
        .o_ovf(ovfb));

    log_prod_accum #(.PROD_W(16), .ACC_W(16), .VEC_LEN(3)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clrc), .i_valid(vc), .o_ready(ordyc),
        .i_prod(prodc), .o_valid(ovalc), .i_ready(rdyc), .o_sum(sumc), .o_count(cntc),
        .o_ovf(ovfc));

    typedef struct {
        logic v;
        int   prod;
        logic rdy;
        logic clr;
        logic e_rdy;
        logic e_val;
        int   e_sum;
        int   e_cnt;
    } vec_t;

    vec_t tbl[$];
    int n_tests = 0;
    int n_fail  = 0;

`ifdef LOG_ACC_SAT_EN
    localparam int EXP_B_SUM = 32767;
    localparam int EXP_B_OVF = 1;
    localparam int EXP_C_SUM = -32768;
    localparam int EXP_C_OVF = 1;
`else
    localparam int EXP_B_SUM = -32768;
    localparam int EXP_B_OVF = 0;
    localparam int EXP_C_SUM = 16384;
    localparam int EXP_C_OVF = 0;
`endif

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Each row: inputs driven for one cycle, outputs expected during that cycle.
    task automatic add(input logic v, input int prod, input logic rdy, input logic clr,
                       input logic e_rdy, input logic e_val, input int e_sum, input int e_cnt);
        vec_t r;
        r.v = v; r.prod = prod; r.rdy = rdy; r.clr = clr;
        r.e_rdy = e_rdy; r.e_val = e_val; r.e_sum = e_sum; r.e_cnt = e_cnt;
        tbl.push_back(r);
    endtask

    initial begin
        // basic vector 100,-50,16384,-1
        add(1, 100,    0, 0, 1, 0, 0, 0);
        add(1, -50,    0, 0, 1, 0, 0, 1);
        add(1, 16384,  0, 0, 1, 0, 0, 2);
        add(1, -1,     0, 0, 1, 0, 0, 3);
        // held in OUT for 5 cycles with i_valid high
        for (int k = 0; k < 5; k++) add(1, 777, 0, 0, 0, 1, 16433, 4);
        add(0, 0,      1, 0, 0, 1, 16433, 4);
        // input gaps: valid 1,0,1,0,1,1 with products 1,2,3,4
        add(1, 1,      0, 0, 1, 0, 16433, 0);
        add(0, 99,     0, 0, 1, 0, 16433, 1);
        add(1, 2,      0, 0, 1, 0, 16433, 1);
        add(0, 99,     0, 0, 1, 0, 16433, 2);
        add(1, 3,      0, 0, 1, 0, 16433, 2);
        add(1, 4,      0, 0, 1, 0, 16433, 3);
        add(0, 0,      1, 0, 0, 1, 10, 4);
        // mid-vector clear drops 500
        add(1, 7,      0, 0, 1, 0, 10, 0);
        add(1, 9,      0, 0, 1, 0, 10, 1);
        add(1, 500,    0, 1, 1, 0, 10, 2);
        add(1, 1,      0, 0, 1, 0, 10, 0);
        add(1, 1,      0, 0, 1, 0, 10, 1);
        add(1, 1,      0, 0, 1, 0, 10, 2);
        add(1, 1,      0, 0, 1, 0, 10, 3);
        add(0, 0,      0, 0, 0, 1, 4, 4);
        add(0, 0,      1, 0, 0, 1, 4, 4);
        // clear while in OUT keeps o_sum
        add(1, -3,     0, 0, 1, 0, 4, 0);
        add(1, -3,     0, 0, 1, 0, 4, 1);
        add(1, -3,     0, 0, 1, 0, 4, 2);
        add(1, -3,     0, 0, 1, 0, 4, 3);
        add(0, 0,      0, 1, 0, 1, -12, 4);
        add(0, 0,      0, 0, 1, 0, -12, 0);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset o_ready", ordya, 1);
        chk("reset o_valid", ovala, 0);
        chk("reset o_sum", suma, 0);
        chk("reset o_count", cnta, 0);
        chk("reset o_ovf", ovfa, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            va = tbl[i].v; proda = 16'(tbl[i].prod); rdya = tbl[i].rdy; clra = tbl[i].clr;
            #1;
            chk($sformatf("row%0d o_ready", i), ordya, tbl[i].e_rdy);
            chk($sformatf("row%0d o_valid", i), ovala, tbl[i].e_val);
            chk($sformatf("row%0d o_sum", i), $signed(suma), tbl[i].e_sum);
            chk($sformatf("row%0d o_count", i), cnta, tbl[i].e_cnt);
            chk($sformatf("row%0d o_ovf", i), ovfa, 0);
        end
        @(negedge clk);
        va = 1'b0; clra = 1'b0; rdya = 1'b0;

        // B: 16384 + 16384 in a 16-bit accumulator
        vb = 1'b1; prodb = 16'sd16384;
        @(negedge clk);
        @(negedge clk);
        vb = 1'b0;
        #1;
        chk("b o_valid", ovalb, 1);
        chk("b o_sum", $signed(sumb), EXP_B_SUM);
        chk("b o_ovf", ovfb, EXP_B_OVF);
        chk("b o_count", cntb, 2);
        rdyb = 1'b1;
        @(negedge clk);
        rdyb = 1'b0;
        #1;
        chk("b after hs o_ready", ordyb, 1);
        chk("b after hs o_ovf", ovfb, 0);
        chk("b after hs o_count", cntb, 0);

        // C: three beats of -16384
        vc = 1'b1; prodc = -16'sd16384;
        repeat (3) @(negedge clk);
        vc = 1'b0;
        #1;
        chk("c o_valid", ovalc, 1);
        chk("c o_sum", $signed(sumc), EXP_C_SUM);
        chk("c o_ovf", ovfc, EXP_C_OVF);

        // A: reach OUT, then asynchronous reset between edges
        va = 1'b1; proda = 16'sd1000;
        repeat (4) @(negedge clk);
        va = 1'b0;
        #1;
        chk("a pre-reset o_valid", ovala, 1);
        chk("a pre-reset o_sum", $signed(suma), 4000);
        rst_n = 1'b0;
        #1;
        chk("async rst o_valid", ovala, 0);
        chk("async rst o_sum", suma, 0);
        chk("async rst o_count", cnta, 0);
        chk("async rst o_ovf", ovfa, 0);
        chk("async rst c o_sum", sumc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post rst o_ready", ordya, 1);
        chk("post rst o_valid", ovala, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/log_prod_accum.md
Name: log_prod_accum

Overview:
- Streaming accumulator directly downstream of the 8x8 signed logarithmic (Mitchell) multiplier.
- Consumes its 16-bit signed products over a valid/ready handshake and sums exactly VEC_LEN of them into a wide signed accumulator.
- Presents each dot-product result on a held valid/ready output.
- Used to form dot products and convolution taps for the log-multiplier error and accuracy studies.

Parameters:
- PROD_W, 16: product input width; matches multiplier output.
- ACC_W, 24: accumulator and result width. Must satisfy ACC_W >= PROD_W.
- VEC_LEN, 16: number of products summed per result. Must be >= 1.
- CNT_W, $clog2(VEC_LEN+1): width of the element counter.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_clear  input  1  synchronous abort/clear of the current vector.
- i_valid  input  1  product beat valid.
- o_ready  output  1  block can accept a product.
- i_prod  input  PROD_W  signed product from the multiplier.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_sum  output  ACC_W  signed accumulated result.
- o_count  output  CNT_W  products accepted in the current vector.
- o_ovf  output  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: state=ACC, acc=0, count=0, o_valid=0, o_sum=0, o_count=0, o_ovf=0. o_ready=1 as soon as reset is released.
- States: ACC and OUT.
  - o_ready = (state==ACC), decoded from registered state only; no combinational path from i_valid or i_ready.
  - o_valid = (state==OUT).
- Input handshake: a beat is accepted when i_valid && o_ready at a rising edge.
- Each accepted beat:
  - acc <= acc + sign_extend(i_prod to ACC_W).
  - count <= count+1.
- Final beat (count==VEC_LEN-1 at the accept edge):
  - o_sum <= acc + sext(i_prod).
  - count <= VEC_LEN.
  - state <= OUT.
  - o_valid rises on the cycle after the final accept (latency 1).
- OUT state:
  - o_sum, o_count and o_valid are held stable until i_ready=1.
  - i_valid is ignored; o_ready=0.
- Output handshake (o_valid && i_ready):
  - acc<=0, count<=0, state<=ACC.
  - o_ready reasserts on the next cycle; no same-cycle accept.
  - Minimum period is VEC_LEN+1 cycles per result.
- i_clear=1 (either state):
  - acc<=0, count<=0, o_valid<=0, state<=ACC, o_ovf<=0.
  - Any input beat presented in the same cycle is dropped.
  - Clear takes priority over every other event; o_sum retains its last value.
- VEC_LEN=1: every accepted beat produces a result; the block alternates ACC and OUT.
- Arithmetic: two's complement at ACC_W bits. Without SAT_EN the sum wraps modulo 2^ACC_W.
- Zero products (including from zero operands) are accumulated normally and counted.
- Asynchronous reset mid-vector or mid-OUT: everything returns to reset values immediately; a partial vector is lost.

Optional Feature:
- Macro: LOG_ACC_SAT_EN.
- Defined:
  - Each addition saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - o_ovf is set whenever a clamp occurs and stays set until the output handshake or i_clear.
  - o_ovf is valid alongside o_sum.
- Undefined:
  - The sum wraps.
  - o_ovf is tied to 0.
  - No saturation logic is synthesized.

Test Plan:
1. VEC_LEN=4, no backpressure. Products 100, -50, 16384, -1 on consecutive cycles -> o_valid high on the cycle after the 4th beat, o_sum=16433, o_count=4. After the i_ready handshake, o_ready=1 and o_count=0.
2. Output backpressure: hold i_ready=0 for 5 cycles in OUT with i_valid=1 -> o_sum is stable, o_ready=0, no beat is accepted. Release i_ready -> the next vector starts cleanly from 0.
3. Input gaps: VEC_LEN=4 with i_valid toggling 1,0,1,0,1,1 and products 1,2,3,4 -> o_sum=10. Idle cycles leave count and acc unchanged.
4. Mid-vector clear: accept 7 and 9, then i_clear=1 while i_valid=1 with 500 -> count=0 and 500 is dropped. Next four beats of 1 -> o_sum=4.
5. ACC_W=16, VEC_LEN=2, products 16384, 16384:
   - With LOG_ACC_SAT_EN -> o_sum=32767, o_ovf=1.
   - Without -> o_sum=-32768, o_ovf=0.
   - With the macro, products -16384, -16384, then -16384 under VEC_LEN=3 -> o_sum=-32768, o_ovf=1.
6. Assert i_rst_n=0 asynchronously in OUT with o_valid=1 -> o_valid, o_sum, o_count and o_ovf go to 0 without waiting for a clock edge. After release, o_ready=1.
